// File: rtl/synth_pkg.sv
// synth_pkg: shared FSM state type and default widths for the noise arbiter
package synth_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [2:0] {RESET_HOLD, WARMUP, IDLE, STEP, ACK} lfsr_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or above the pointer, wrapping round
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  // scan NUM_REQ positions starting at the pointer and keep the first hit
  always_comb begin
    logic found;
    logic [IW-1:0] j;
    found = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[j]) begin
        found = 1'b1;
        idx_o = j;
        gnt_o = NUM_REQ'(1) << j;
      end
    end
  end
endmodule

// File: rtl/lfsr_noise_arb.sv
// lfsr_noise_arb: round-robin sharing of one lfsr among voices; warm-up gated by LFSR_NOISE_ARB_WARMUP_EN
module lfsr_noise_arb
  import synth_pkg::*;
#(
`ifdef LFSR_NOISE_ARB_WARMUP_EN
  parameter int WARMUP_CYCLES = 32,
`endif
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [DATA_W-1:0]  noise_data_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic [15:0]        served_cnt_o,
  output logic               lfsr_en_o,
  output logic               lfsr_rst_o,
  input  logic [DATA_W-1:0]  lfsr_data_i
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  lfsr_arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, gidx_q, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt, gnt_q, ack_q;
  logic [DATA_W-1:0] noise_q;
  logic [15:0] cnt_q;
  logic ready_q, en_q, hit, wu_done;
`ifdef LFSR_NOISE_ARB_WARMUP_EN
  localparam lfsr_arb_state_t AFTER_RESET = WARMUP;
  localparam logic [7:0] WU_LAST = 8'(WARMUP_CYCLES - 1);
  logic [7:0] wu_q;
  assign wu_done = wu_q == WU_LAST;
  // warm-up step counter, only runs while in WARMUP
  always_ff @(posedge clk) begin
    if (reset || state_q != WARMUP) wu_q <= '0;
    else wu_q <= wu_q + 8'd1;
  end
`else
  localparam lfsr_arb_state_t AFTER_RESET = IDLE;
  assign wu_done = 1'b1;
`endif
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );
  assign hit = req_i[gidx_q];
  // next-state: a grant always walks IDLE -> STEP -> ACK -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_HOLD: state_d = AFTER_RESET;
      WARMUP:     state_d = wu_done ? IDLE : WARMUP;
      IDLE:       state_d = |req_i ? STEP : IDLE;
      STEP:       state_d = ACK;
      ACK:        state_d = IDLE;
      default:    state_d = RESET_HOLD;
    endcase
  end
  // state, grant capture and registered outputs; ack only if the voice still wants it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_HOLD;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      noise_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= state_d == WARMUP || state_d == STEP;
      ready_q <= ready_q | (state_d == IDLE);
      ack_q   <= '0;
      if (state_q == IDLE) begin
        gidx_q <= arb_idx;
        gnt_q  <= arb_gnt;
      end
      if (state_q == ACK && hit) begin
        ack_q   <= gnt_q;
        noise_q <= lfsr_data_i;
        cnt_q   <= cnt_q + 16'd1;
        ptr_q   <= (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
      end
    end
  end
  assign ack_o        = ack_q;
  assign noise_data_o = noise_q;
  assign ready_o      = ready_q;
  assign busy_o       = state_q == STEP || state_q == ACK;
  assign served_cnt_o = cnt_q;
  assign lfsr_en_o    = reset | en_q;
  assign lfsr_rst_o   = reset;
endmodule

// File: tb/tb_lfsr_noise_arb.sv
// tb_lfsr_noise_arb: scoreboard bench with a behavioural lfsr standing in for the parent's generator
module tb_lfsr_noise_arb;
`ifdef LFSR_NOISE_ARB_WARMUP_EN
  localparam int WU = 32;
`else
  localparam int WU = 0;
`endif
  typedef struct { int idx; logic [15:0] data; } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] ack;
  logic [15:0] noise, served, lfsr_data, gen_q, gen_ref, exp_served;
  logic ready, busy, lfsr_en, lfsr_rst;
  int n_vec = 0, n_err = 0, cyc = 0, t0;
  exp_t sb[$];
  int ack_cycs[$];
  exp_t e;
  logic [3:0] oh;
  lfsr_noise_arb dut (
    .clk(clk), .reset(reset), .req_i(req), .ack_o(ack), .noise_data_o(noise),
    .ready_o(ready), .busy_o(busy), .served_cnt_o(served), .lfsr_en_o(lfsr_en),
    .lfsr_rst_o(lfsr_rst), .lfsr_data_i(lfsr_data)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lfsr_en) gen_q <= lfsr_rst ? 16'h0 : lstep(gen_q);
  end
  assign lfsr_data = gen_q;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input int idx);
    gen_ref = lstep(gen_ref);
    sb.push_back('{idx, gen_ref});
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
    sb.delete();
  endtask
  task automatic do_reset();
    int lat;
    reset = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_noise", noise, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_served", served, 0);
    check("rst_lfsr_rst", lfsr_rst, 1);
    check("rst_lfsr_en", lfsr_en, 1);
    sb.delete();
    exp_served = '0;
    gen_ref = '0;
    for (int i = 0; i < WU; i++) gen_ref = lstep(gen_ref);
    reset = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 400);
    check("ready_lat", lat, WU + 1);
  endtask
  always @(negedge clk) begin
    if (ack != 0) begin
      ack_cycs.push_back(cyc);
      if (sb.size() == 0) check("spurious_ack", ack, 0);
      else begin
        e = sb.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        check("ack_vec", ack, oh);
        check("sample", noise, e.data);
        exp_served = exp_served + 16'd1;
        check("served", served, exp_served);
      end
    end
  end
  initial begin
    do_reset();
    ack_cycs.delete();
    t0 = cyc;
    req = 4'b0001;
    push(0); push(0); push(0);
    drain(60);
    req = '0;
    check("n_acks", ack_cycs.size(), 3);
    if (ack_cycs.size() == 3) begin
      check("first_lat", ack_cycs[0] - t0, 3);
      check("gap1", ack_cycs[1] - ack_cycs[0], 3);
      check("gap2", ack_cycs[2] - ack_cycs[1], 3);
    end
    repeat (3) @(negedge clk);
    check("served3", served, 3);
    check("noise_hold", noise, gen_ref);
    do_reset();
    req = 4'b1111;
    push(0); push(1); push(2); push(3); push(0);
    drain(100);
    req = 4'b1010;
    push(1); push(3); push(1);
    drain(100);
    req = '0;
    repeat (3) @(negedge clk);
    req = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    check("step_busy", busy, 1);
    check("step_en", lfsr_en, 1);
    req = '0;
    gen_ref = lstep(gen_ref);
    repeat (4) @(negedge clk);
    check("drop_served", served, exp_served);
    check("drop_busy", busy, 0);
    req = 4'b0101;
    push(2);
    drain(60);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("ack_state_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_en", lfsr_en, 1);
    check("mid_rst_rst", lfsr_rst, 1);
    check("mid_rst_served", served, 0);
    do_reset();
    req = 4'b0001;
    push(0);
    drain(60);
    req = '0;
    repeat (3) @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    exp_served = 16'hFFFE;
    ack_cycs.delete();
    req = 4'b0001;
    push(0); push(0);
    drain(60);
    req = '0;
    check("wrap_served", served, 0);
    if (ack_cycs.size() == 2) check("wrap_gap", ack_cycs[1] - ack_cycs[0], 3);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
